// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the instruction-fetch front end:
//   - fetch_state_t : fetch controller FSM states
//   - RESET_PC_DEFAULT : default first fetch address after reset
//   - NOP_WORD : all-zero instruction word used as the cleared value
//   - pc_plus4() : sequential next-PC, wraps modulo 2^32
// -----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    // Unsigned add; the carry out of bit 31 is dropped, so 0xFFFF_FFFC -> 0.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// -----------------------------------------------------------------------------
// fetch_skid
// One-entry instruction/PC buffer. Catches a word that returns from
// instruction memory while the IF output register is full and stalled.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   i_load            : capture i_instr/i_pc, mark entry valid
//   i_unload          : drop the entry (consumed or discarded)
//   i_instr, i_pc     : word and its address to capture
//   o_valid           : entry holds a word
//   o_instr, o_pc     : buffered word and its address
// -----------------------------------------------------------------------------
module fetch_skid
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_unload,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the data fields are reset as well as the valid bit, so the
            // buffer never feeds an X into the IF register after reset.
            r_valid <= 1'b0;
            r_instr <= NOP_WORD;
            r_pc    <= 32'h0000_0000;
        end else begin
            if (i_load) begin
                r_valid <= 1'b1;
                r_instr <= i_instr;
                r_pc    <= i_pc;
            end else if (i_unload) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch controller: issues word-aligned reads to instruction
// memory, delivers fetched words to decode through the if_* register, absorbs
// one word of back-pressure in a skid buffer, and handles PC redirects.
// Parameter:
//   RESET_PC        : first fetch address after reset
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   stall           : decode not accepting; if_* held while high
//   redirect_valid  : one-cycle pulse, take redirect_pc (bits [1:0] ignored)
//   imem_req/addr   : read request and word-aligned address
//   imem_ack/rdata  : read complete and returned word
//   if_valid/instr/pc/pc4 : word handed to decode, its address, address + 4
// Build option:
//   FETCH_CTRL_DELAY_SLOT_EN : when defined, exactly one sequential word after
//   a redirecting branch (the branch delay slot) is delivered.
// -----------------------------------------------------------------------------
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
);

`ifdef FETCH_CTRL_DELAY_SLOT_EN
    localparam bit DS_EN = 1'b1;
`else
    localparam bit DS_EN = 1'b0;
`endif

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic         r_pend, w_pend_nxt;
    logic [31:0]  r_pend_pc, w_pend_pc_nxt;
    logic         r_ds_owed, w_ds_owed_nxt;
    logic         r_if_valid, w_if_valid_nxt;
    logic [31:0]  r_if_instr, w_if_instr_nxt;
    logic [31:0]  r_if_pc, w_if_pc_nxt;
    logic [31:0]  r_if_pc4, w_if_pc4_nxt;

    logic [31:0]  w_redir_pc;
    logic         w_ds_slot;
    logic         w_keep_word;
    logic         w_take_ack;
    logic         w_take_skid;
    logic         w_skid_load;
    logic         w_skid_unload;
    logic         w_skid_valid;
    logic [31:0]  w_skid_instr;
    logic [31:0]  w_skid_pc;

    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

    // The delay slot is still owed when it has not been delivered yet: for a
    // fresh redirect that means nothing is live in if_*; while a redirect is
    // pending it is whatever was recorded when the redirect arrived.
    assign w_ds_slot = DS_EN && (r_pend ? r_ds_owed : !r_if_valid);

    fetch_skid u_skid (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_instr  (imem_rdata),
        .i_pc     (r_pc),
        .o_valid  (w_skid_valid),
        .o_instr  (w_skid_instr),
        .o_pc     (w_skid_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_nxt     = r_pend;
        w_pend_pc_nxt  = r_pend_pc;
        w_ds_owed_nxt  = r_ds_owed;
        w_keep_word    = 1'b0;
        w_take_ack     = 1'b0;
        w_take_skid    = 1'b0;
        w_skid_load    = 1'b0;
        w_skid_unload  = 1'b0;
        // A live word is consumed on any cycle decode is not stalling.
        w_if_valid_nxt = r_if_valid && stall;
        w_if_instr_nxt = r_if_instr;
        w_if_pc_nxt    = r_if_pc;
        w_if_pc4_nxt   = r_if_pc4;

        case (r_state)
            ST_IDLE: begin
                if (redirect_valid) begin
                    w_pc_nxt = w_redir_pc;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        // Coincident word survives only as an owed delay slot;
                        // if_* is empty in that case, so it loads directly.
                        w_take_ack    = w_ds_slot;
                        w_pc_nxt      = w_redir_pc;
                        w_pend_nxt    = 1'b0;
                        w_ds_owed_nxt = 1'b0;
                    end else begin
                        // Request must stay stable, so remember the target
                        // until the outstanding read returns.
                        w_pend_nxt    = 1'b1;
                        w_pend_pc_nxt = w_redir_pc;
                        w_ds_owed_nxt = w_ds_slot;
                    end
                end else if (imem_ack) begin
                    w_keep_word   = !r_pend || r_ds_owed;
                    w_pc_nxt      = r_pend ? r_pend_pc : pc_plus4(r_pc);
                    w_pend_nxt    = 1'b0;
                    w_ds_owed_nxt = 1'b0;
                    if (w_keep_word) begin
                        if (!r_if_valid || !stall) begin
                            w_take_ack = 1'b1;
                        end else begin
                            w_skid_load = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (redirect_valid) begin
                    w_skid_unload = 1'b1;
                    w_pc_nxt      = w_redir_pc;
                    w_state_nxt   = ST_FETCH;
                end else if (!stall) begin
                    w_take_skid   = w_skid_valid;
                    w_skid_unload = 1'b1;
                    w_state_nxt   = ST_FETCH;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Redirect flushes the IF register even under stall; with delay slots
        // enabled the live word is the slot and follows the normal stall rule.
        if (redirect_valid && !DS_EN) begin
            w_if_valid_nxt = 1'b0;
        end

        if (w_take_ack) begin
            w_if_valid_nxt = 1'b1;
            w_if_instr_nxt = imem_rdata;
            w_if_pc_nxt    = r_pc;
            w_if_pc4_nxt   = pc_plus4(r_pc);
        end else if (w_take_skid) begin
            w_if_valid_nxt = 1'b1;
            w_if_instr_nxt = w_skid_instr;
            w_if_pc_nxt    = w_skid_pc;
            w_if_pc4_nxt   = pc_plus4(w_skid_pc);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC_ALIGNED;
            r_pend     <= 1'b0;
            r_pend_pc  <= 32'h0000_0000;
            r_ds_owed  <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_instr <= NOP_WORD;
            r_if_pc    <= 32'h0000_0000;
            r_if_pc4   <= 32'h0000_0000;
        end else begin
            r_pc       <= w_pc_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_pc  <= w_pend_pc_nxt;
            r_ds_owed  <= w_ds_owed_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_pc4   <= w_if_pc4_nxt;
        end
    end

    // Request is a pure function of state, so reset removes it immediately.
    assign imem_req  = (r_state == ST_FETCH);
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign if_pc4    = r_if_pc4;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl. Inputs change on the falling edge, outputs
// are checked on the falling edge. A second instance starts near the top of
// the address space to exercise PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

`ifdef FETCH_CTRL_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;

    logic        wrap_stall;
    logic        wrap_rv;
    logic [31:0] wrap_rpc;
    logic        wrap_req;
    logic [31:0] wrap_addr;
    logic        wrap_ack;
    logic [31:0] wrap_rdata;
    logic        wrap_valid;
    logic [31:0] wrap_instr;
    logic [31:0] wrap_pc;
    logic [31:0] wrap_pc4;

    int n_checks;
    int n_errors;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .stall          (wrap_stall),
        .redirect_valid (wrap_rv),
        .redirect_pc    (wrap_rpc),
        .imem_req       (wrap_req),
        .imem_addr      (wrap_addr),
        .imem_ack       (wrap_ack),
        .imem_rdata     (wrap_rdata),
        .if_valid       (wrap_valid),
        .if_instr       (wrap_instr),
        .if_pc          (wrap_pc),
        .if_pc4         (wrap_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Apply inputs for the coming rising edge, then move to the next falling edge.
    task automatic drive(input logic ack, input logic [31:0] rdata, input logic stl,
                         input logic rv, input logic [31:0] rpc);
        imem_ack       = ack;
        imem_rdata     = rdata;
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        wrap_stall     = 1'b0;
        wrap_rv        = 1'b0;
        wrap_rpc       = 32'h0;
        wrap_ack       = 1'b0;
        wrap_rdata     = 32'h0;

        // Reset state
        @(negedge clk);
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc",    if_pc, 32'h0);
        check("rst_pc4",   if_pc4, 32'h0);
        check("rst_addr",  imem_addr, 32'h0000_3000);
        check("rst_wrap_addr", wrap_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);     // IDLE -> FETCH

        // Back-to-back fetch, ack every cycle
        check("seq_req",   32'(imem_req), 32'd1);
        check("seq_addr0", imem_addr, 32'h0000_3000);
        check("seq_nv",    32'(if_valid), 32'd0);
        drive(1'b1, word_at(32'h3000), 1'b0, 1'b0, 32'h0);
        check("seq_addr1", imem_addr, 32'h0000_3004);
        check("seq_v0",    32'(if_valid), 32'd1);
        check("seq_pc0",   if_pc, 32'h0000_3000);
        check("seq_ins0",  if_instr, word_at(32'h3000));
        check("seq_pc4_0", if_pc4, 32'h0000_3004);
        drive(1'b1, word_at(32'h3004), 1'b0, 1'b0, 32'h0);
        check("seq_addr2", imem_addr, 32'h0000_3008);
        check("seq_pc1",   if_pc, 32'h0000_3004);
        check("seq_pc4_1", if_pc4, 32'h0000_3008);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("consumed_nv", 32'(if_valid), 32'd0);
        check("noack_addr",  imem_addr, 32'h0000_3008);

        // Stall with back-pressure into the skid buffer
        drive(1'b1, word_at(32'h3008), 1'b0, 1'b0, 32'h0);
        check("pre_stall_pc", if_pc, 32'h0000_3008);
        drive(1'b1, word_at(32'h300C), 1'b1, 1'b0, 32'h0);
        check("hold_req1",   32'(imem_req), 32'd0);
        check("hold_pc1",    if_pc, 32'h0000_3008);
        check("hold_instr1", if_instr, word_at(32'h3008));
        check("hold_valid1", 32'(if_valid), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("hold_req2",   32'(imem_req), 32'd0);
        check("hold_instr2", if_instr, word_at(32'h3008));
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("hold_pc3",    if_pc, 32'h0000_3008);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("skid_pc",     if_pc, 32'h0000_300C);
        check("skid_instr",  if_instr, word_at(32'h300C));
        check("skid_req",    32'(imem_req), 32'd1);
        check("skid_addr",   imem_addr, 32'h0000_3010);

        // Redirect while request outstanding, ack two cycles later
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_4000);
        check("pend_nv",    32'(if_valid), 32'd0);
        check("pend_addr1", imem_addr, 32'h0000_3010);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("pend_addr2", imem_addr, 32'h0000_3010);
        drive(1'b1, word_at(32'h3010), 1'b0, 1'b0, 32'h0);
        check("pend_drop_nv", 32'(if_valid), 32'd0);
        check("pend_tgt",     imem_addr, 32'h0000_4000);
        drive(1'b1, word_at(32'h4000), 1'b0, 1'b0, 32'h0);
        check("tgt_pc",   if_pc, 32'h0000_4000);
        check("tgt_addr", imem_addr, 32'h0000_4004);

        // Redirect coincident with ack, empty IF register; low target bits ignored
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("co_pre_nv", 32'(if_valid), 32'd0);
        drive(1'b1, word_at(32'h4004), 1'b0, 1'b1, 32'h0000_4002);
        check("co_addr",  imem_addr, 32'h0000_4000);
        check("co_valid", 32'(if_valid), 32'(DS));
        check("co_pc",    if_pc, DS ? 32'h0000_4004 : 32'h0000_4000);
        drive(1'b1, word_at(32'h4000), 1'b0, 1'b0, 32'h0);
        check("co_next_pc",    if_pc, 32'h0000_4000);
        check("co_next_valid", 32'(if_valid), 32'd1);
        check("co_next_addr",  imem_addr, 32'h0000_4004);

        // Two redirects while pending: last target wins
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_5000);
        check("r2_nv",   32'(if_valid), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_6000);
        drive(1'b1, word_at(32'h4004), 1'b0, 1'b0, 32'h0);
        check("r2_addr", imem_addr, 32'h0000_6000);
        check("r2_drop", 32'(if_valid), 32'd0);

        // Redirect while in HOLD under stall
        drive(1'b1, word_at(32'h6000), 1'b0, 1'b0, 32'h0);
        check("h_pc", if_pc, 32'h0000_6000);
        drive(1'b1, word_at(32'h6004), 1'b1, 1'b0, 32'h0);
        check("h_req", 32'(imem_req), 32'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_7000);
        check("hr_addr",  imem_addr, 32'h0000_7000);
        check("hr_req",   32'(imem_req), 32'd1);
        check("hr_valid", 32'(if_valid), 32'(DS));
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("hr_nv", 32'(if_valid), 32'd0);
        drive(1'b1, word_at(32'h7000), 1'b0, 1'b0, 32'h0);
        check("hr_tgt_pc",    if_pc, 32'h0000_7000);
        check("hr_tgt_instr", if_instr, word_at(32'h7000));
        check("hr_tgt_addr",  imem_addr, 32'h0000_7004);

        // Reset asserted mid-FETCH, late ack after release must be ignored
        imem_ack = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mrst_req",   32'(imem_req), 32'd0);
        check("mrst_addr",  imem_addr, 32'h0000_3000);
        check("mrst_valid", 32'(if_valid), 32'd0);
        @(negedge clk);
        drive(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        drive(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
        check("late_req",   32'(imem_req), 32'd1);
        check("late_addr",  imem_addr, 32'h0000_3000);
        check("late_valid", 32'(if_valid), 32'd0);
        check("late_instr", if_instr, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // PC wrap on the second instance
        check("wrap_addr0", wrap_addr, 32'hFFFF_FFF8);
        wrap_ack   = 1'b1;
        wrap_rdata = word_at(32'hFFFF_FFF8);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("wrap_addr1", wrap_addr, 32'hFFFF_FFFC);
        check("wrap_pc0",   wrap_pc, 32'hFFFF_FFF8);
        check("wrap_pc4_0", wrap_pc4, 32'hFFFF_FFFC);
        wrap_rdata = word_at(32'hFFFF_FFFC);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("wrap_addr2", wrap_addr, 32'h0000_0000);
        check("wrap_pc1",   wrap_pc, 32'hFFFF_FFFC);
        check("wrap_pc4_1", wrap_pc4, 32'h0000_0000);
        wrap_rdata = word_at(32'h0000_0000);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("wrap_addr3", wrap_addr, 32'h0000_0004);
        check("wrap_pc2",   wrap_pc, 32'h0000_0000);
        check("wrap_instr2", wrap_instr, word_at(32'h0000_0000));
        check("wrap_valid", 32'(wrap_valid), 32'd1);
        wrap_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
